// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's load/store path and the data-memory responder.
// A transfer on either channel happens on a rising edge where its valid and ready are both high.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: word RAM with byte strobes, wait states, error flag.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           dbg_state_o
);
  localparam int unsigned CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             error_q, error_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [31:0] offset;
  logic [29:0] index;
  logic [AW-1:0] ram_idx;
  logic        req_err;
  logic        accept;
  logic        mem_we;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign offset  = bus.req_addr - BASE_ADDR;
  assign index   = offset[31:2];
  assign ram_idx = index[AW-1:0];
  assign req_err = (bus.req_addr[1:0] != 2'b00) || ({2'b00, index} >= DEPTH_WORDS);
  assign accept  = (state_q == S_IDLE) && bus.req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          error_d = req_err;
          rdata_d = (!req_err && !bus.req_write) ? mem_q[ram_idx] : 32'h0;
          mem_we  = !req_err && bus.req_write;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // RAM is never cleared; a store commits on its accept edge.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wstrb[b]) mem_q[ram_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances cover 1, 3 and 0 wait states
// and a non-zero base address.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  logic [1:0] dbg_a, dbg_b, dbg_c;

  always #5 clk = ~clk;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();
  data_mem_responder_if ifc ();

  data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1))
    dut_a (.clock(clk), .reset(rst), .bus(ifa.slave), .dbg_state_o(dbg_a));
  data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3))
    dut_b (.clock(clk), .reset(rst), .bus(ifb.slave), .dbg_state_o(dbg_b));
  data_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0))
    dut_c (.clock(clk), .reset(rst), .bus(ifc.slave), .dbg_state_o(dbg_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer on instance A (1 wait state) with resp_ready held high.
  task automatic a_xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(ifa.req_ready), 32'd1);
    ifa.req_valid = 1'b1;
    ifa.req_write = wr;
    ifa.req_addr  = addr;
    ifa.req_wdata = wdata;
    ifa.req_wstrb = strb;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    chk({tag, "_wait"}, 32'(ifa.resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(ifa.resp_valid), 32'd1);
    chk({tag, "_rdata"}, ifa.resp_rdata, exp_d);
    chk({tag, "_err"}, 32'(ifa.resp_error), 32'(exp_e));
  endtask

  // One load on instance C (no wait states).
  task automatic c_single(input string tag, input logic [31:0] addr, input logic exp_e);
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b0;
    ifc.req_addr  = addr;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    chk({tag, "_valid"}, 32'(ifc.resp_valid), 32'd1);
    chk({tag, "_rdata"}, ifc.resp_rdata, 32'h0);
    chk({tag, "_err"}, 32'(ifc.resp_error), 32'(exp_e));
    @(negedge clk);
  endtask

  // Stream item i: four stores to 0x1000..0x100C, then four loads back.
  task automatic c_drive(input int i);
    logic [31:0] d;
    d = 32'h0BAD_0000 + 32'(i % 4) * 32'h0101_0101;
    ifc.req_write = (i < 4);
    ifc.req_addr  = 32'h0000_1000 + 32'(4 * (i % 4));
    ifc.req_wdata = d;
    ifc.req_wstrb = 4'b1111;
    exp_q.push_back((i < 4) ? 32'h0 : d);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    ifa.req_valid = 0; ifa.req_write = 0; ifa.req_addr = 0; ifa.req_wdata = 0; ifa.req_wstrb = 0;
    ifb.req_valid = 0; ifb.req_write = 0; ifb.req_addr = 0; ifb.req_wdata = 0; ifb.req_wstrb = 0;
    ifc.req_valid = 0; ifc.req_write = 0; ifc.req_addr = 0; ifc.req_wdata = 0; ifc.req_wstrb = 0;
    ifa.resp_ready = 1'b1; ifb.resp_ready = 1'b1; ifc.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", 32'(ifa.req_ready), 32'd1);
    chk("rst_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rst_rdata", ifa.resp_rdata, 32'h0);
    chk("rst_err", 32'(ifa.resp_error), 32'd0);
    chk("rst_state", 32'(dbg_a), 32'd0);

    // Basic store/load, byte lanes, empty strobe.
    a_xfer("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    a_xfer("ld_full", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0);
    a_xfer("st_lane", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
    a_xfer("ld_lane", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);
    a_xfer("st_none", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    a_xfer("ld_none", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);

    // Errors: out-of-range store must not alias onto word 0.
    a_xfer("st_w0", 1'b1, 32'h0, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
    a_xfer("st_oor", 1'b1, 32'h400, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    a_xfer("ld_w0", 1'b0, 32'h0, 32'h0, 4'b0000, 32'h1234_5678, 1'b0);
    a_xfer("ld_mis", 1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 1'b1);
    a_xfer("ld_oor", 1'b0, 32'h400, 32'h0, 4'b0000, 32'h0, 1'b1);

    // Backpressure: response held five cycles while a store is offered and ignored.
    @(negedge clk);
    ifa.resp_ready = 1'b0;
    ifa.req_valid = 1'b1; ifa.req_write = 1'b0; ifa.req_addr = 32'h10;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    chk("bp_wstate", 32'(dbg_a), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 32'h10;
      ifa.req_wdata = 32'h0; ifa.req_wstrb = 4'b1111;
      @(negedge clk);
      chk("bp_valid", 32'(ifa.resp_valid), 32'd1);
      chk("bp_rdata", ifa.resp_rdata, 32'hDE22_BE44);
      chk("bp_err", 32'(ifa.resp_error), 32'd0);
      chk("bp_ready", 32'(ifa.req_ready), 32'd0);
    end
    ifa.req_valid = 1'b0;
    ifa.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", 32'(ifa.resp_valid), 32'd0);
    chk("bp_rel_ready", 32'(ifa.req_ready), 32'd1);
    a_xfer("bp_after", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0);

    // Instance C: base 0x1000, 16 words, no wait states.
    c_single("c_below", 32'h0000_0FFC, 1'b1);
    c_single("c_above", 32'h0000_1040, 1'b1);

    @(negedge clk);
    ifc.req_valid = 1'b1;
    c_drive(0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      chk("b2b_valid", 32'(ifc.resp_valid), 32'd1);
      chk("b2b_busy", 32'(ifc.req_ready), 32'd0);
      chk("b2b_rdata", ifc.resp_rdata, e);
      if (i < 7) c_drive(i + 1);
      else ifc.req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_gap_valid", 32'(ifc.resp_valid), 32'd0);
      chk("b2b_gap_ready", 32'(ifc.req_ready), 32'd1);
    end

    // Instance B: reset during WAIT drops the response but keeps the store.
    @(negedge clk);
    ifb.req_valid = 1'b1; ifb.req_write = 1'b1; ifb.req_addr = 32'h20;
    ifb.req_wdata = 32'hCAFE_F00D; ifb.req_wstrb = 4'b1111;
    @(negedge clk);
    ifb.req_valid = 1'b0;
    chk("rw_wait_valid", 32'(ifb.resp_valid), 32'd0);
    chk("rw_wait_state", 32'(dbg_b), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_rst_valid", 32'(ifb.resp_valid), 32'd0);
    chk("rw_rst_ready", 32'(ifb.req_ready), 32'd1);
    chk("rw_rst_rdata", ifb.resp_rdata, 32'h0);
    chk("rw_rst_err", 32'(ifb.resp_error), 32'd0);
    chk("rw_rst_state", 32'(dbg_b), 32'd0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ifb.resp_valid) seen++;
    end
    chk("rw_no_resp", 32'(seen), 32'd0);

    ifb.req_valid = 1'b1; ifb.req_write = 1'b0; ifb.req_addr = 32'h20;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) ifb.req_valid = 1'b0;
      if (lat == 0 && ifb.resp_valid) begin
        lat = k;
        chk("rw_ld_rdata", ifb.resp_rdata, 32'hCAFE_F00D);
        chk("rw_ld_err", 32'(ifb.resp_error), 32'd0);
      end
    end
    chk("rw_ld_latency", 32'(lat), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
